// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register offsets, register index enum
// and the byte-lane merge used by every writable register.
package gpio_pkg;

   localparam logic [7:0] GPIO_DATA_OUT = 8'h00;
   localparam logic [7:0] GPIO_DATA_IN  = 8'h04;
   localparam logic [7:0] GPIO_DIR      = 8'h08;
   localparam logic [7:0] GPIO_RISE_EN  = 8'h0C;
   localparam logic [7:0] GPIO_FALL_EN  = 8'h10;
   localparam logic [7:0] GPIO_PEND     = 8'h14;
   localparam logic [7:0] GPIO_DEBOUNCE = 8'h18;
   localparam logic [7:0] GPIO_RESERVED = 8'h1C;

   typedef enum logic [2:0] {
      REG_DATA_OUT = 3'd0,
      REG_DATA_IN  = 3'd1,
      REG_DIR      = 3'd2,
      REG_RISE_EN  = 3'd3,
      REG_FALL_EN  = 3'd4,
      REG_PEND     = 3'd5,
      REG_DEBOUNCE = 3'd6,
      REG_RESERVED = 3'd7
   } reg_idx_e;

   // Bytes whose lane bit is set come from new_value, the rest keep old_value.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                               input logic [31:0] new_value,
                                               input logic [3:0]  lanes);
      logic [31:0] result;
      result = old_value;
      for (int b = 0; b < 4; b++) begin
         if (lanes[b]) result[8*b +: 8] = new_value[8*b +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: synchroniser chain, two-tick debounce filter and
// edge outputs computed from the value stable is about to take.
module gpio_debounce #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   input  logic bypass,
   input  logic tick,
   output logic stable,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   sync;
   logic                   sample;
   logic                   stable_next;

   assign sync = chain[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain  <= '0;
         sample <= 1'b0;
         stable <= 1'b0;
      end else begin
         chain  <= {chain[SYNC_STAGES-2:0], pin};
         stable <= stable_next;
         if (!bypass && tick) sample <= sync;
      end
   end

   // A new level is accepted only when two consecutive ticks saw it.
   always_comb begin
      stable_next = stable;
      if (bypass) begin
         stable_next = sync;
      end else if (tick && (sync == sample)) begin
         stable_next = sync;
      end
   end

   assign rise = stable_next & ~stable;
   assign fall = ~stable_next & stable;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-bit direction, debounced inputs, edge
// interrupts with W1C pending bits, byte-masked single-cycle bus access.
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               DEB_BITS    = 16,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      address_in,
   input  logic             sel_in,
   input  logic             read_in,
   input  logic [3:0]       write_mask_in,
   input  logic [31:0]      write_value_in,
   output logic [31:0]      read_value_out,
   output logic             ready_out,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq_out
);

   reg_idx_e            idx;
   logic [WIDTH-1:0]    data_out, dir, rise_en, fall_en, pend;
   logic [WIDTH-1:0]    stable, rise, fall;
   logic [WIDTH-1:0]    pend_clear;
   logic [DEB_BITS-1:0] debounce, prescale;
   logic                bypass, tick, deb_write;
   logic                unused_bus;

   assign idx        = reg_idx_e'(address_in[4:2]);
   assign unused_bus = ^{read_in, address_in[31:5], address_in[1:0]};
   assign bypass     = (debounce == '0);
   assign tick       = !bypass && (prescale == debounce - 1'b1);
   assign deb_write  = sel_in && (idx == REG_DEBOUNCE) && (write_mask_in != 4'b0000);
   assign pend_clear = (sel_in && idx == REG_PEND)
                       ? WIDTH'(merge_bytes(32'd0, write_value_in, write_mask_in)) : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out <= OUT_RESET;
         dir      <= DIR_RESET;
         rise_en  <= '0;
         fall_en  <= '0;
         debounce <= '0;
      end else if (sel_in) begin
         case (idx)
            REG_DATA_OUT: data_out <= WIDTH'(merge_bytes(32'(data_out), write_value_in, write_mask_in));
            REG_DIR:      dir      <= WIDTH'(merge_bytes(32'(dir), write_value_in, write_mask_in));
            REG_RISE_EN:  rise_en  <= WIDTH'(merge_bytes(32'(rise_en), write_value_in, write_mask_in));
            REG_FALL_EN:  fall_en  <= WIDTH'(merge_bytes(32'(fall_en), write_value_in, write_mask_in));
            REG_DEBOUNCE: debounce <= DEB_BITS'(merge_bytes(32'(debounce), write_value_in, write_mask_in));
            default: ;
         endcase
      end
   end

   // Shared prescaler; restarting it on a DEBOUNCE write keeps tick spacing exact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescale <= '0;
      end else if (deb_write || bypass || tick) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   // A new event wins over a same-edge W1C so no edge is ever lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~pend_clear) | (rise & rise_en) | (fall & fall_en);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      gpio_debounce #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
         .clk    (clk),
         .reset  (reset),
         .pin    (gpio_in[i]),
         .bypass (bypass),
         .tick   (tick),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   always_comb begin
      read_value_out = 32'd0;
      if (sel_in) begin
         case (idx)
            REG_DATA_OUT: read_value_out = 32'(data_out);
            REG_DATA_IN:  read_value_out = 32'(stable);
            REG_DIR:      read_value_out = 32'(dir);
            REG_RISE_EN:  read_value_out = 32'(rise_en);
            REG_FALL_EN:  read_value_out = 32'(fall_en);
            REG_PEND:     read_value_out = 32'(pend);
            REG_DEBOUNCE: read_value_out = 32'(debounce);
            default:      read_value_out = 32'd0;
         endcase
      end
   end

   assign ready_out = sel_in;
   assign gpio_out  = data_out;
   assign gpio_oe   = dir;
   assign irq_out   = |pend;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: three instances (8, 32 and 5 channels)
// share one bus; expected values are queued at stimulus time and popped at sampling.
module tb_gpio_bank;
   import gpio_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address = 32'd0;
   logic        sel = 1'b0;
   logic        read = 1'b0;
   logic [3:0]  mask = 4'd0;
   logic [31:0] wdata = 32'd0;

   logic [7:0]  gpio8_in = 8'd0;
   logic [7:0]  gpio8_out, gpio8_oe;
   logic [31:0] rdata8;
   logic        ready8, irq8;

   logic [31:0] gpio32_in = 32'd0;
   logic [31:0] gpio32_out, gpio32_oe;
   logic [31:0] rdata32;
   logic        ready32, irq32;

   logic [4:0]  gpio5_in = 5'd0;
   logic [4:0]  gpio5_out, gpio5_oe;
   logic [31:0] rdata5;
   logic        ready5, irq5;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          accept_cycle;
   bit          seen;

   always #5 clk = ~clk;

   gpio_bank #(.WIDTH(8), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F)) dut8 (
      .clk(clk), .reset(reset), .address_in(address), .sel_in(sel), .read_in(read),
      .write_mask_in(mask), .write_value_in(wdata), .read_value_out(rdata8),
      .ready_out(ready8), .gpio_in(gpio8_in), .gpio_out(gpio8_out), .gpio_oe(gpio8_oe),
      .irq_out(irq8));

   gpio_bank #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .address_in(address), .sel_in(sel), .read_in(read),
      .write_mask_in(mask), .write_value_in(wdata), .read_value_out(rdata32),
      .ready_out(ready32), .gpio_in(gpio32_in), .gpio_out(gpio32_out), .gpio_oe(gpio32_oe),
      .irq_out(irq32));

   gpio_bank #(.WIDTH(5)) dut5 (
      .clk(clk), .reset(reset), .address_in(address), .sel_in(sel), .read_in(read),
      .write_mask_in(mask), .write_value_in(wdata), .read_value_out(rdata5),
      .ready_out(ready5), .gpio_in(gpio5_in), .gpio_out(gpio5_out), .gpio_oe(gpio5_oe),
      .irq_out(irq5));

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic expect_value(input string tag, input logic [31:0] value);
      exp_q.push_back(value);
      tag_q.push_back(tag);
   endtask

   task automatic compare_next(input logic [31:0] actual);
      if (exp_q.size() == 0) begin
         check_output("scoreboard_empty", actual, 32'hFFFF_FFFF ^ actual);
      end else begin
         check_output(tag_q.pop_front(), actual, exp_q.pop_front());
      end
   endtask

   function automatic logic [31:0] read_of(input int which);
      case (which)
         8:       return rdata8;
         32:      return rdata32;
         default: return rdata5;
      endcase
   endfunction

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] value, input logic [3:0] lanes);
      @(negedge clk);
      address = {27'd0, idx, 2'b00};
      sel     = 1'b1;
      mask    = lanes;
      wdata   = value;
      @(negedge clk);
      sel     = 1'b0;
      mask    = 4'd0;
   endtask

   task automatic bus_read(input int which, input logic [2:0] idx, input string tag, input logic [31:0] value);
      @(negedge clk);
      address = {27'd0, idx, 2'b00};
      sel     = 1'b1;
      mask    = 4'd0;
      expect_value(tag, value);
      #1;
      compare_next(read_of(which));
      sel     = 1'b0;
   endtask

   task automatic check_now(input string tag, input logic [31:0] actual, input logic [31:0] value);
      expect_value(tag, value);
      compare_next(actual);
   endtask

   initial begin
      #12000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values while reset is held low
      #12;
      check_now("reset_gpio_out", 32'(gpio8_out), 32'h0000_00A5);
      check_now("reset_gpio_oe", 32'(gpio8_oe), 32'h0000_000F);
      check_now("reset_irq", 32'(irq8), 32'd0);
      address = {27'd0, REG_PEND, 2'b00};
      sel = 1'b1;
      #1;
      check_now("reset_pend", rdata8, 32'd0);
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Byte-masked write and deselected read
      bus_write(REG_DATA_OUT, 32'hDEAD_BEEF, 4'b0101);
      bus_read(32, REG_DATA_OUT, "mask_read32", 32'h00AD_00EF);
      check_now("mask_gpio_out32", gpio32_out, 32'h00AD_00EF);
      @(negedge clk);
      address = 32'd0;
      sel = 1'b0;
      #1;
      check_now("desel_read", rdata32, 32'd0);
      check_now("desel_ready", 32'(ready32), 32'd0);
      sel = 1'b1;
      #1;
      check_now("sel_ready", 32'(ready32), 32'd1);
      sel = 1'b0;

      // Bypass path latency and rising-edge interrupt
      bus_write(REG_RISE_EN, 32'h0000_0001, 4'b0001);
      address = {27'd0, REG_DATA_IN, 2'b00};
      sel = 1'b1;
      gpio8_in[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_now("bypass_early_data", rdata8, 32'd0);
      check_now("bypass_early_irq", 32'(irq8), 32'd0);
      @(posedge clk);
      #1;
      check_now("bypass_data", rdata8, 32'h01);
      check_now("bypass_irq", 32'(irq8), 32'd1);
      sel = 1'b0;
      bus_read(8, REG_PEND, "bypass_pend", 32'h01);
      bus_write(REG_PEND, 32'h01, 4'b0001);
      bus_read(8, REG_PEND, "w1c_pend", 32'h00);
      check_now("w1c_irq", 32'(irq8), 32'd0);

      // Debounce: short pulse rejected, long level accepted within bound
      bus_write(REG_DEBOUNCE, 32'd10, 4'b0011);
      bus_write(REG_RISE_EN, 32'h08, 4'b0001);
      @(negedge clk);
      gpio8_in[3] = 1'b1;
      repeat (5) @(negedge clk);
      gpio8_in[3] = 1'b0;
      repeat (30) @(negedge clk);
      bus_read(8, REG_DATA_IN, "glitch_data", 32'h01);
      bus_read(8, REG_PEND, "glitch_pend", 32'h00);
      @(negedge clk);
      gpio8_in[3] = 1'b1;
      address = {27'd0, REG_DATA_IN, 2'b00};
      sel = 1'b1;
      seen = 1'b0;
      accept_cycle = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (rdata8[3]) begin
            seen = 1'b1;
            accept_cycle = k;
         end
      end
      sel = 1'b0;
      check_now("deb_accepted", 32'(seen), 32'd1);
      check_now("deb_in_time", 32'(accept_cycle <= 24), 32'd1);
      bus_read(8, REG_PEND, "deb_pend", 32'h08);
      bus_write(REG_PEND, 32'h08, 4'b0001);

      // W1C racing a falling edge: the new event must survive
      bus_write(REG_DEBOUNCE, 32'd0, 4'b0011);
      @(negedge clk);
      gpio8_in[1] = 1'b1;
      repeat (5) @(negedge clk);
      bus_read(8, REG_PEND, "rise_disabled_pend", 32'h00);
      bus_write(REG_FALL_EN, 32'h02, 4'b0001);
      @(negedge clk);
      gpio8_in[1] = 1'b0;
      @(negedge clk);
      bus_write(REG_PEND, 32'h02, 4'b0001);
      bus_read(8, REG_PEND, "race_pend", 32'h02);
      check_now("race_irq", 32'(irq8), 32'd1);
      bus_write(REG_PEND, 32'h02, 4'b0001);
      bus_read(8, REG_PEND, "race_cleared", 32'h00);
      check_now("race_irq_low", 32'(irq8), 32'd0);

      // Narrow instance: bits above WIDTH and reserved offset
      bus_write(REG_DIR, 32'hFF, 4'b0001);
      bus_read(5, REG_DIR, "w5_dir", 32'h1F);
      check_now("w5_oe", 32'(gpio5_oe), 32'h1F);
      bus_write(REG_RISE_EN, 32'hFF, 4'b0001);
      bus_read(5, REG_RISE_EN, "w5_rise_en", 32'h1F);
      bus_write(REG_RESERVED, 32'hFFFF_FFFF, 4'b1111);
      bus_read(5, REG_RESERVED, "w5_reserved", 32'h0);
      bus_read(5, REG_DIR, "w5_dir_kept", 32'h1F);
      bus_read(5, REG_DATA_OUT, "w5_data_kept", 32'h0F);
      bus_write(REG_DEBOUNCE, 32'hFFFF_FFFF, 4'b1111);
      bus_read(5, REG_DEBOUNCE, "w5_debounce", 32'h0000_FFFF);
      bus_write(REG_DEBOUNCE, 32'd0, 4'b1111);

      // Reset in the middle of activity
      @(negedge clk);
      gpio8_in[2] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_now("pre_reset_irq", 32'(irq8), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_now("midreset_irq", 32'(irq8), 32'd0);
      check_now("midreset_out", 32'(gpio8_out), 32'hA5);
      check_now("midreset_oe", 32'(gpio8_oe), 32'h0F);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_now("post_reset_irq", 32'(irq8), 32'd0);
      bus_read(8, REG_PEND, "post_reset_pend", 32'h00);
      bus_read(8, REG_DATA_IN, "post_reset_data", 32'h0D);

      if (exp_q.size() != 0) check_output("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
